// File: rtl/instr_encoder.sv
// Packs R-type/LW/SW/BEQ field requests into 32-bit RISC-V words and writes them
// to consecutive instruction-memory addresses during a program load.
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [9:0]  funct_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  input  logic        last_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [8:0]  count_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  state_t      stateReg, stateNext;
  logic [8:0]  countReg;
  logic        errReg;
  logic        weReg;
  logic [31:0] addrReg;
  logic [31:0] dataReg;
  logic        xfer;
  logic        restart;
  logic [31:0] encWord;

  always_comb begin
    encWord = 32'h0;
    case (op_i)
      OP_R:   encWord = {funct_i[9:3], rs2_i, rs1_i, funct_i[2:0], rd_i, 7'b0110011};
      OP_LW:  encWord = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
      OP_SW:  encWord = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
      OP_BEQ: encWord = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                         imm_i[4:1], imm_i[11], 7'b1100011};
      default: encWord = 32'h0;
    endcase
  end

  // Capacity is 256 words: count bit 8 set means memory is full.
  assign ready_o = (stateReg == RUN) && !countReg[8];
  assign xfer    = valid_i && ready_o;
  assign restart = start_i && (stateReg != RUN);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start_i) stateNext = RUN;
      RUN:     if (xfer && (last_i || countReg == 9'd255)) stateNext = DONE;
      DONE:    if (start_i) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg <= IDLE;
      countReg <= 9'd0;
      errReg   <= 1'b0;
      weReg    <= 1'b0;
      addrReg  <= 32'h0;
      dataReg  <= 32'h0;
    end else begin
      stateReg <= stateNext;
      weReg    <= xfer;
      if (restart) begin
        countReg <= 9'd0;
        errReg   <= 1'b0;
      end
      if (xfer) begin
        addrReg  <= {21'b0, countReg, 2'b00};
        dataReg  <= encWord;
        countReg <= countReg + 9'd1;
        // Misaligned branch target: word still written, bit 0 is simply not encoded.
        if (op_i == OP_BEQ && imm_i[0]) errReg <= 1'b1;
      end
    end
  end

  assign mem_we_o   = weReg;
  assign mem_addr_o = addrReg;
  assign mem_data_o = dataReg;
  assign count_o    = countReg;
  assign done_o     = (stateReg == DONE);
  assign err_o      = errReg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected writes are queued when requests are
// driven and popped by a monitor whenever the write strobe is seen.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rstI, startI, validI, lastI;
  logic [1:0]  opI;
  logic [9:0]  functI;
  logic [4:0]  rdI, rs1I, rs2I;
  logic [12:0] immI;
  logic        readyO, memWeO, doneO, errO;
  logic [31:0] memAddrO, memDataO;
  logic [8:0]  countO;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  mRun   = 1'b0;
  int  mCount = 0;

  instr_encoder dut (
    .clk_i(clk), .rst_i(rstI), .start_i(startI), .valid_i(validI), .ready_o(readyO),
    .op_i(opI), .funct_i(functI), .rd_i(rdI), .rs1_i(rs1I), .rs2_i(rs2I),
    .imm_i(immI), .last_i(lastI), .mem_we_o(memWeO), .mem_addr_o(memAddrO),
    .mem_data_o(memDataO), .count_o(countO), .done_o(doneO), .err_o(errO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  // Bit-field placement of each format, built position by position.
  function automatic logic [31:0] encode(input logic [1:0] op, input logic [9:0] funct,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    logic [31:0] w;
    w = 32'h0;
    case (op)
      2'b00: begin
        w[6:0] = 7'h33; w[11:7] = rd; w[14:12] = funct[2:0];
        w[19:15] = rs1; w[24:20] = rs2; w[31:25] = funct[9:3];
      end
      2'b01: begin
        w[6:0] = 7'h03; w[11:7] = rd; w[14:12] = 3'd2;
        w[19:15] = rs1; w[31:20] = imm[11:0];
      end
      2'b10: begin
        w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[14:12] = 3'd2;
        w[19:15] = rs1; w[24:20] = rs2; w[31:25] = imm[11:5];
      end
      default: begin
        w[6:0] = 7'h63; w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = 3'd0;
        w[19:15] = rs1; w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12];
      end
    endcase
    return w;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [9:0] funct, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm, input logic last);
    wr_t e;
    opI = op; functI = funct; rdI = rd; rs1I = rs1; rs2I = rs2; immI = imm; lastI = last;
    validI = 1'b1;
    if (!rstI && mRun && mCount < 256) begin
      e.addr = 32'(mCount * 4);
      e.data = encode(op, funct, rd, rs1, rs2, imm);
      sb.push_back(e);
      mCount++;
      if (last || mCount == 256) mRun = 1'b0;
    end
    @(posedge clk); #1;
    validI = 1'b0;
    lastI  = 1'b0;
  endtask

  task automatic doStart();
    startI = 1'b1;
    if (!mRun) begin
      mRun = 1'b1;
      mCount = 0;
    end
    @(posedge clk); #1;
    startI = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (memWeO === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", memAddrO, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", memAddrO, e.addr);
        check("wr_data", memDataO, e.data);
      end
    end
  end

  initial begin
    rstI = 1'b1; startI = 1'b0; validI = 1'b0; lastI = 1'b0;
    opI = 2'b00; functI = 10'h0; rdI = 5'd0; rs1I = 5'd0; rs2I = 5'd0; immI = 13'h0;
    idle(2);
    @(negedge clk);
    check("rst_ready", 32'(readyO), 32'd0);
    check("rst_we", 32'(memWeO), 32'd0);
    check("rst_addr", memAddrO, 32'h0);
    check("rst_data", memDataO, 32'h0);
    check("rst_count", 32'(countO), 32'd0);
    check("rst_done", 32'(doneO), 32'd0);
    check("rst_err", 32'(errO), 32'd0);
    rstI = 1'b0;

    // Request while idle is ignored.
    drive(2'b00, 10'h3FF, 5'd7, 5'd7, 5'd7, 13'h0, 1'b0);
    @(negedge clk);
    check("idle_ignore_count", 32'(countO), 32'd0);

    // R-type (imm is don't-care), ends the program.
    doStart();
    @(negedge clk);
    check("run_ready", 32'(readyO), 32'd1);
    drive(2'b00, 10'h000, 5'd3, 5'd1, 5'd2, 13'h1ABC, 1'b1);
    @(negedge clk);
    check("r_data", memDataO, 32'h002081B3);
    check("r_addr", memAddrO, 32'h0);
    check("r_count", 32'(countO), 32'd1);
    idle(1);
    @(negedge clk);
    check("hold_data", memDataO, 32'h002081B3);

    // Back-to-back LW then SW, then BEQ with last.
    doStart();
    drive(2'b01, 10'h2AA, 5'd5, 5'd2, 5'd31, 13'd8, 1'b0);
    @(negedge clk);
    check("lw_data", memDataO, 32'h00812283);
    check("lw_addr", memAddrO, 32'h0);
    drive(2'b10, 10'h155, 5'd9, 5'd2, 5'd5, 13'd12, 1'b0);
    @(negedge clk);
    check("sw_data", memDataO, 32'h00512623);
    check("sw_addr", memAddrO, 32'h4);
    drive(2'b11, 10'h0, 5'd0, 5'd1, 5'd2, 13'd8, 1'b1);
    @(negedge clk);
    check("beq_data", memDataO, 32'h00208463);
    check("beq_done", 32'(doneO), 32'd1);
    check("beq_ready", 32'(readyO), 32'd0);
    drive(2'b01, 10'h0, 5'd1, 5'd1, 5'd1, 13'd4, 1'b0);
    @(negedge clk);
    check("done_ignore_count", 32'(countO), 32'd3);

    // Misaligned BEQ: sticky error, start ignored while running.
    doStart();
    drive(2'b11, 10'h0, 5'd0, 5'd1, 5'd2, 13'd9, 1'b0);
    @(negedge clk);
    check("mis_data", memDataO, 32'h00208463);
    check("mis_err", 32'(errO), 32'd1);
    drive(2'b00, 10'h100, 5'd4, 5'd5, 5'd6, 13'd0, 1'b0);
    doStart();
    @(negedge clk);
    check("run_start_count", 32'(countO), 32'd2);
    check("err_sticky", 32'(errO), 32'd1);
    drive(2'b01, 10'h0, 5'd1, 5'd2, 5'd3, 13'h7FF, 1'b1);
    doStart();
    @(negedge clk);
    check("restart_err", 32'(errO), 32'd0);
    check("restart_count", 32'(countO), 32'd0);
    check("restart_done", 32'(doneO), 32'd0);

    // Capacity: 256 transfers without last.
    for (int i = 0; i < 256; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      drive(op, 10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            13'($urandom) & 13'h1FFE, 1'b0);
    end
    @(negedge clk);
    check("cap_addr", memAddrO, 32'h3FC);
    check("cap_count", 32'(countO), 32'd256);
    check("cap_done", 32'(doneO), 32'd1);
    check("cap_ready", 32'(readyO), 32'd0);
    drive(2'b00, 10'h0, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);

    // Reset in the cycle after a transfer.
    doStart();
    drive(2'b01, 10'h0, 5'd8, 5'd9, 5'd0, 13'd16, 1'b0);
    rstI = 1'b1;
    mRun = 1'b0;
    mCount = 0;
    @(posedge clk); #1;
    rstI = 1'b0;
    @(negedge clk);
    check("mrst_we", 32'(memWeO), 32'd0);
    check("mrst_addr", memAddrO, 32'h0);
    check("mrst_data", memDataO, 32'h0);
    check("mrst_count", 32'(countO), 32'd0);
    check("mrst_done", 32'(doneO), 32'd0);
    check("mrst_ready", 32'(readyO), 32'd0);
    check("mrst_err", 32'(errO), 32'd0);

    // Reset concurrent with a valid request wins.
    doStart();
    rstI = 1'b1;
    mRun = 1'b0;
    drive(2'b00, 10'h0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    rstI = 1'b0;
    @(negedge clk);
    check("rstv_we", 32'(memWeO), 32'd0);
    check("rstv_count", 32'(countO), 32'd0);
    check("rstv_ready", 32'(readyO), 32'd0);

    idle(2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
